// File: rtl/rosc_pkg.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module      : rosc_pkg
// Description : Shared types and constants for the ring-oscillator bank meter.
//               FSM state encoding, settle length, divider tap, and the gate
//               delay used by simulation models of the ring gates.
// Revision    : 1.0 - initial release
// ============================================================================
package rosc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } rosc_state_e;

    // clk cycles allowed for a stopped ring and its counter to become static
    localparam int unsigned SETTLE_CYCLES = 4;

    // ring-counter bit exported on ring_div (ring frequency / 16)
    localparam int unsigned DIV_BIT = 3;

    // per-gate delay of the ring in simulation models
    localparam int unsigned SIM_GATE_DLY = 1;

    // select width that stays legal for a single-ring bank
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rosc_ring.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module      : rosc_ring
// Description : One NAND-gated inverter ring oscillator with a saturating
//               rising-edge counter clocked by the ring itself.
// Ports       : en_i       - ring enable (clk-domain flop); ring runs while 1
//               clr_i      - asynchronous clear of the edge counter
//               ring_out_o - ring tap, 0 whenever the ring is stopped
//               cnt_o      - saturating rising-edge count of ring_out_o
// Parameters  : STAGES (even inverter count), CNT_W (counter width)
// Revision    : 1.0 - initial release
// ============================================================================
module rosc_ring
    import rosc_pkg::*;
#(
    parameter int unsigned STAGES = 100,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             en_i,
    input  logic             clr_i,
    output logic             ring_out_o,
    output logic [CNT_W-1:0] cnt_o
);

    // w_stage[0] is the enable NAND output, w_stage[k] the k-th inverter.
    // With an even inverter count the loop has an odd number of inversions.
    logic             w_stage [0:STAGES];
    logic [CNT_W-1:0] cnt_q;

`ifndef SYNTHESIS
    assign #(SIM_GATE_DLY) w_stage[0] = ~(en_i & w_stage[STAGES]);
`else
    assign w_stage[0] = ~(en_i & w_stage[STAGES]);
`endif

    for (genvar k = 1; k <= STAGES; k++) begin : g_inv
`ifndef SYNTHESIS
        assign #(SIM_GATE_DLY) w_stage[k] = ~w_stage[k-1];
`else
        assign w_stage[k] = ~w_stage[k-1];
`endif
    end

    // Stopped ring forces the NAND output to 1, so the first inverter sits
    // at 0: this tap is quiet-low whenever the ring is disabled.
    assign ring_out_o = w_stage[1];

    // Read only while the ring is stopped, so no synchroniser is needed.
    always_ff @(posedge w_stage[1] or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/rosc_bank_meter.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module      : rosc_bank_meter
// Description : Bank of NUM_RINGS gated ring oscillators of increasing length
//               with a gated frequency meter. A clk-domain FSM enables the
//               selected ring for `window` clk cycles, lets it settle, then
//               captures its rising-edge count. done pulses window+7 cycles
//               after the cycle in which an accepted start was presented.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               start    - begin a measurement (ignored unless idle)
//               sel      - ring select, sampled on accepted start
//               window   - enable length in clk cycles, sampled on start
//               busy     - high from accepted start until done
//               done     - one-cycle pulse, count/overflow valid
//               count    - captured rising-edge count
//               overflow - counter saturated during the last measurement
//               ring_out - selected ring output, 0 while disabled
//               ring_div - selected ring counter bit DIV_BIT (optional)
// Options     : ROSC_DIV_OUT_EN - when defined, drive ring_div from the
//               selected ring counter; otherwise ring_div is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rosc_bank_meter
    import rosc_pkg::*;
#(
    parameter int unsigned NUM_RINGS  = 4,
    parameter int unsigned STAGES     = 100,
    parameter int unsigned STAGE_STEP = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WIN_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [sel_width(NUM_RINGS)-1:0]   sel,
    input  logic [WIN_W-1:0]                  window,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  count,
    output logic                              overflow,
    output logic                              ring_out,
    output logic                              ring_div
);

    localparam int unsigned SEL_W  = sel_width(NUM_RINGS);
    localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES);

    rosc_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [WIN_W-1:0]  wcnt_q, wcnt_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [NUM_RINGS-1:0] en_q, en_d;
    logic              clr_q, clr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [NUM_RINGS-1:0] w_tap;
    logic [CNT_W-1:0]     w_cnt [NUM_RINGS];
    logic [CNT_W-1:0]     w_sel_cnt;

    for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
        rosc_ring #(
            .STAGES (STAGES + 2 * i * STAGE_STEP),
            .CNT_W  (CNT_W)
        ) u_ring (
            .en_i       (en_q[i]),
            .clr_i      (clr_q),
            .ring_out_o (w_tap[i]),
            .cnt_o      (w_cnt[i])
        );
    end

    assign w_sel_cnt = w_cnt[sel_q];

    // ------------------------------------------------------------------
    // State and datapath registers. clr resets high so every ring counter
    // is held cleared (ring_div quiet) throughout reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            wcnt_q     <= '0;
            scnt_q     <= '0;
            en_q       <= '0;
            clr_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wcnt_q     <= wcnt_d;
            scnt_q     <= scnt_d;
            en_q       <= en_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = (wcnt_q == '0) ? ST_SETTLE : ST_RUN;
            ST_RUN:     if (wcnt_q == WIN_W'(1)) state_d = ST_SETTLE;
            ST_SETTLE:  if (scnt_q == SCNT_W'(SETTLE_CYCLES - 1)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        sel_d      = sel_q;
        wcnt_d     = wcnt_q;
        scnt_d     = scnt_q;
        en_d       = en_q;
        clr_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d  = sel;
                    wcnt_d = window;
                    busy_d = 1'b1;
                    clr_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                scnt_d = '0;
                // enable rises here and falls on the edge where the window
                // counter reads 1, giving exactly `window` enabled cycles
                if (wcnt_q != '0) begin
                    en_d        = '0;
                    en_d[sel_q] = 1'b1;
                end
            end
            ST_RUN: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WIN_W'(1)) begin
                    en_d = '0;
                end
            end
            ST_SETTLE: begin
                scnt_d = scnt_q + 1'b1;
            end
            ST_CAPTURE: begin
                count_d    = w_sel_cnt;
                overflow_d = &w_sel_cnt;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                en_d = '0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign ring_out = w_tap[sel_q] & en_q[sel_q];

`ifdef ROSC_DIV_OUT_EN
    assign ring_div = w_sel_cnt[DIV_BIT];
`else
    assign ring_div = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rosc_bank_meter.sv
`default_nettype none
`timescale 1ns/1ns
// ============================================================================
// Module      : tb_rosc_bank_meter
// Description : Self-checking bench for rosc_bank_meter. Expected counts come
//               from ring physics: period = 2*(inverters+1) gate delays, so a
//               window of W clk cycles yields about 10*W/period rising edges.
//               A second instance with CNT_W=8 exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rosc_bank_meter;

    localparam int CLK_PERIOD = 10;
    localparam int STAGES     = 100;
    localparam int STAGE_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start8;
    logic [1:0]  sel, sel8;
    logic [15:0] window, window8;
    logic        busy, done, overflow, ring_out, ring_div;
    logic [15:0] count;
    logic        busy8, done8, overflow8, ring_out8, ring_div8;
    logic [7:0]  count8;

    int n_pass  = 0;
    int n_total = 0;
    int ro_tog  = 0;

    always #(CLK_PERIOD / 2) clk = ~clk;
    always @(ring_out) ro_tog++;

    rosc_bank_meter #(
        .NUM_RINGS(4), .STAGES(STAGES), .STAGE_STEP(STAGE_STEP), .CNT_W(16), .WIN_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .window(window),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .ring_out(ring_out), .ring_div(ring_div)
    );

    rosc_bank_meter #(
        .NUM_RINGS(4), .STAGES(STAGES), .STAGE_STEP(STAGE_STEP), .CNT_W(8), .WIN_W(16)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .window(window8),
        .busy(busy8), .done(done8), .count(count8), .overflow(overflow8),
        .ring_out(ring_out8), .ring_div(ring_div8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_rng(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    // Reference: whole ring periods that fit into the enabled time, saturated.
    function automatic int model_count(input int ring, input int w, input int cntw);
        int period = 2 * (STAGES + 2 * ring * STAGE_STEP + 1);
        int raw    = (CLK_PERIOD * w) / period;
        int sat    = (1 << cntw) - 1;
        return (raw > sat) ? sat : raw;
    endfunction

    task automatic drive(input bit u8, input bit st, input int s, input int w);
        if (u8) begin
            start8 = st; sel8 = s[1:0]; window8 = w[15:0];
        end else begin
            start = st; sel = s[1:0]; window = w[15:0];
        end
    endtask

    // Presents start for one cycle, optionally re-pulses start (sel 3,
    // window 5) after edge `repulse_at`, and records the first done.
    task automatic run_meas(input bit u8, input int s, input int w, input int repulse_at,
                            output int lat, output logic [31:0] cnt, output logic ov,
                            output int ndone, output logic b1);
        bit got = 0;
        lat = 0; cnt = 'x; ov = 1'bx; ndone = 0; b1 = 1'bx;
        @(posedge clk); #1;
        drive(u8, 1'b1, s, w);
        for (int n = 1; n <= w + 40; n++) begin
            @(posedge clk); #1;
            if (n == repulse_at) drive(u8, 1'b1, 3, 5);
            else                 drive(u8, 1'b0, s, w);
            if (n == 1) b1 = u8 ? busy8 : busy;
            if (u8 ? done8 : done) begin
                ndone++;
                if (!got) begin
                    got = 1;
                    lat = n;
                    cnt = u8 ? {24'b0, count8} : {16'b0, count};
                    ov  = u8 ? overflow8 : overflow;
                end
            end
            if (got && n >= lat + 10) break;
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nd, tog0, exp_c, rs, rw;
        logic [31:0] cnt;
        logic        ov, b1;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_count", {16'b0, count}, 0);
        check("rst_overflow", {31'b0, overflow}, 0);
        check("rst_ring_out", {31'b0, ring_out}, 0);
        check("rst_ring_div", {31'b0, ring_div}, 0);
        @(negedge clk) rst_n = 1'b1;
        tog0 = ro_tog;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_toggle", ro_tog - tog0, 0);
        check("idle_busy", {31'b0, busy}, 0);

        // directed windows on three ring lengths
        for (int r = 0; r < 4; r++) begin
            if (r == 2) continue;
            tog0 = ro_tog;
            run_meas(1'b0, r, 1000, 0, lat, cnt, ov, nd, b1);
            exp_c = model_count(r, 1000, 16);
            check("w1000_busy", {31'b0, b1}, 1);
            check("w1000_latency", lat, 1007);
            check_rng("w1000_count", cnt, exp_c - 1, exp_c + 1);
            check("w1000_overflow", {31'b0, ov}, 0);
            check("w1000_single_done", nd, 1);
            check_rng("w1000_ring_toggles", ro_tog - tog0, 2, 1000);
        end

        // zero window: ring never enabled
        tog0 = ro_tog;
        run_meas(1'b0, 2, 0, 0, lat, cnt, ov, nd, b1);
        check("w0_latency", lat, 7);
        check("w0_count", cnt, 0);
        check("w0_overflow", {31'b0, ov}, 0);
        check("w0_no_toggle", ro_tog - tog0, 0);

        // random rings and windows against the period model
        for (int k = 0; k < 4; k++) begin
            rs = int'($urandom_range(0, 3));
            rw = int'($urandom_range(40, 1500));
            run_meas(1'b0, rs, rw, 0, lat, cnt, ov, nd, b1);
            exp_c = model_count(rs, rw, 16);
            check("rand_latency", lat, rw + 7);
            check_rng("rand_count", cnt, exp_c - 1, exp_c + 1);
            check("rand_overflow", {31'b0, ov}, 0);
        end

        // start re-pulsed mid-RUN is ignored
        run_meas(1'b0, 0, 300, 100, lat, cnt, ov, nd, b1);
        exp_c = model_count(0, 300, 16);
        check("repulse_latency", lat, 307);
        check("repulse_single_done", nd, 1);
        check_rng("repulse_count", cnt, exp_c - 1, exp_c + 1);

        // 8-bit counter saturates, then a short run reports normally
        run_meas(1'b1, 0, 8000, 0, lat, cnt, ov, nd, b1);
        check("sat_latency", lat, 8007);
        check("sat_count", cnt, 255);
        check("sat_overflow", {31'b0, ov}, 1);
        run_meas(1'b1, 0, 100, 0, lat, cnt, ov, nd, b1);
        exp_c = model_count(0, 100, 8);
        check_rng("post_sat_count", cnt, exp_c - 1, exp_c + 1);
        check("post_sat_overflow", {31'b0, ov}, 0);

        // reset in the middle of RUN
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 2, 500);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2, 500);
        repeat (100) @(posedge clk);
        #3;
        check("midrst_busy_before", {31'b0, busy}, 1);
        check_rng("midrst_ring_running", ro_tog - tog0, 1, 32'h7fff_ffff);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_count", {16'b0, count}, 0);
        check("midrst_ring_out", {31'b0, ring_out}, 0);
        tog0 = ro_tog;
        #30;
        check("midrst_stopped", ro_tog - tog0, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midrst_no_done", nd, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
